// File: rtl/block_memory_retrieval_pkg.sv
// Shared geometry, FSM encoding and HCM word layout for the hit storage memories.
package block_memory_retrieval_pkg;

  localparam int unsigned SSIDBITS         = 12;
  localparam int unsigned COLINDEXBITS_HNM = 5;
  localparam int unsigned ROWINDEXBITS_HNM = SSIDBITS - COLINDEXBITS_HNM;
  localparam int unsigned NCOLS_HNM        = 2 ** COLINDEXBITS_HNM;
  localparam int unsigned HITINFOBITS      = 8;
  localparam int unsigned MAXHITNBITS      = 4;
  localparam int unsigned MAXHITS          = 8;
  localparam int unsigned NCOLS_HIM        = MAXHITS * HITINFOBITS;
  localparam int unsigned ROWINDEXBITS_HIM = 9;
  localparam int unsigned NCOLS_HCM        = ROWINDEXBITS_HIM + MAXHITNBITS;
  localparam int unsigned NHITBITS         = $clog2(MAXHITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP_WAIT,
    LOOKUP_CHECK,
    LIST_WAIT,
    LIST_CHECK,
    EMIT
  } state_e;

  function automatic logic [MAXHITNBITS-1:0] hcm_count(input logic [NCOLS_HCM-1:0] w);
    return w[MAXHITNBITS-1:0];
  endfunction

  function automatic logic [ROWINDEXBITS_HIM-1:0] hcm_him_addr(input logic [NCOLS_HCM-1:0] w);
    return w[NCOLS_HCM-1 -: ROWINDEXBITS_HIM];
  endfunction

  // Stored count saturated to the number of slots a HIM row actually holds.
  function automatic logic [NHITBITS-1:0] clamp_hits(input logic [MAXHITNBITS-1:0] c);
    if (32'(c) > MAXHITS) return NHITBITS'(MAXHITS);
    return NHITBITS'(c);
  endfunction

endpackage

// File: rtl/block_memory_retrieval_hit_row_serializer.sv
// Loads one HIM row plus a hit count and shifts the hits out, slot 0 first, one per cycle.
module block_memory_retrieval_hit_row_serializer
  import block_memory_retrieval_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic                   abort_i,
  input  logic [NCOLS_HIM-1:0]   row_i,
  input  logic [NHITBITS-1:0]    count_i,
  output logic [HITINFOBITS-1:0] word_o,
  output logic                   valid_o,
  output logic                   last_o,
  output logic [NHITBITS-1:0]    remaining_o
);

  logic [NCOLS_HIM-1:0]   row_q, row_d;
  logic [NHITBITS-1:0]    rem_q, rem_d;
  logic [HITINFOBITS-1:0] word_q, word_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;

  always_comb begin
    row_d   = row_q;
    rem_d   = rem_q;
    word_d  = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    if (abort_i) begin
      rem_d = '0;
    end else if (load_i) begin
      word_d  = row_i[HITINFOBITS-1:0];
      row_d   = row_i >> HITINFOBITS;
      rem_d   = (count_i == '0) ? '0 : count_i - NHITBITS'(1);
      valid_d = (count_i != '0);
      last_d  = (count_i == NHITBITS'(1));
    end else if (rem_q != '0) begin
      word_d  = row_q[HITINFOBITS-1:0];
      row_d   = row_q >> HITINFOBITS;
      rem_d   = rem_q - NHITBITS'(1);
      valid_d = 1'b1;
      last_d  = (rem_q == NHITBITS'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q   <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      row_q   <= row_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign word_o      = word_q;
  assign valid_o     = valid_q;
  assign last_o      = last_q;
  assign remaining_o = rem_q;

endmodule

// File: rtl/block_memory_retrieval.sv
// Read side of the hit store: HNM bit test, HCM count/address lookup, then HIM row streamed out.
module block_memory_retrieval
  import block_memory_retrieval_pkg::*;
(
  input  logic                        clock,
  input  logic                        resetN,
  input  logic                        memoryBusy,
  input  logic                        readRequest,
  input  logic [SSIDBITS-1:0]         readSSID,
  output logic                        readReady,
  output logic [ROWINDEXBITS_HNM-1:0] rowIndexA_HNM,
  input  logic [NCOLS_HNM-1:0]        dataOutputA_HNM,
  output logic [SSIDBITS-1:0]         rowIndexA_HCM,
  input  logic [NCOLS_HCM-1:0]        dataOutputA_HCM,
  output logic [ROWINDEXBITS_HIM-1:0] rowIndexA_HIM,
  input  logic [NCOLS_HIM-1:0]        dataOutputA_HIM,
  output logic                        hitValid,
  output logic [HITINFOBITS-1:0]      hitInfo,
  output logic                        lastHit,
  output logic                        readDone,
  output logic                        noHits,
  output logic                        countOverflow,
  output logic                        readAborted
);

  state_e                      state_q, state_d;
  logic [COLINDEXBITS_HNM-1:0] col_q, col_d;
  logic [NHITBITS-1:0]         n_q, n_d;
  logic                        ovf_pend_q, ovf_pend_d;
  logic [ROWINDEXBITS_HNM-1:0] hnm_addr_q, hnm_addr_d;
  logic [SSIDBITS-1:0]         hcm_addr_q, hcm_addr_d;
  logic [ROWINDEXBITS_HIM-1:0] him_addr_q, him_addr_d;
  logic                        done_q, done_d;
  logic                        no_hits_q, no_hits_d;
  logic                        ovf_q, ovf_d;
  logic                        aborted_q, aborted_d;
  logic                        load_c, abort_c;
  logic [NHITBITS-1:0]         ser_remaining;

  assign readReady = resetN && (state_q == IDLE) && !memoryBusy;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    n_d        = n_q;
    ovf_pend_d = ovf_pend_q;
    hnm_addr_d = hnm_addr_q;
    hcm_addr_d = hcm_addr_q;
    him_addr_d = him_addr_q;
    done_d     = 1'b0;
    no_hits_d  = 1'b0;
    ovf_d      = 1'b0;
    aborted_d  = 1'b0;
    load_c     = 1'b0;
    abort_c    = 1'b0;
    // The writer taking the memories pre-empts any query in flight.
    if (state_q != IDLE && memoryBusy) begin
      state_d   = IDLE;
      done_d    = 1'b1;
      aborted_d = 1'b1;
      abort_c   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (readRequest && readReady) begin
            hnm_addr_d = readSSID[SSIDBITS-1:COLINDEXBITS_HNM];
            hcm_addr_d = readSSID;
            col_d      = readSSID[COLINDEXBITS_HNM-1:0];
            state_d    = LOOKUP_WAIT;
          end
        end
        LOOKUP_WAIT: state_d = LOOKUP_CHECK;
        LOOKUP_CHECK: begin
          if (!dataOutputA_HNM[col_q] || hcm_count(dataOutputA_HCM) == '0) begin
            done_d    = 1'b1;
            no_hits_d = 1'b1;
            state_d   = IDLE;
          end else begin
            n_d        = clamp_hits(hcm_count(dataOutputA_HCM));
            ovf_pend_d = 32'(hcm_count(dataOutputA_HCM)) > MAXHITS;
            him_addr_d = hcm_him_addr(dataOutputA_HCM);
            state_d    = LIST_WAIT;
          end
        end
        LIST_WAIT: state_d = LIST_CHECK;
        LIST_CHECK: begin
          load_c = 1'b1;
          if (n_q == NHITBITS'(1)) begin
            done_d  = 1'b1;
            ovf_d   = ovf_pend_q;
            state_d = IDLE;
          end else begin
            state_d = EMIT;
          end
        end
        EMIT: begin
          // Serializer is about to present its final word on this edge.
          if (ser_remaining == NHITBITS'(1)) begin
            done_d  = 1'b1;
            ovf_d   = ovf_pend_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      col_q      <= '0;
      n_q        <= '0;
      ovf_pend_q <= 1'b0;
      hnm_addr_q <= '0;
      hcm_addr_q <= '0;
      him_addr_q <= '0;
      done_q     <= 1'b0;
      no_hits_q  <= 1'b0;
      ovf_q      <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      n_q        <= n_d;
      ovf_pend_q <= ovf_pend_d;
      hnm_addr_q <= hnm_addr_d;
      hcm_addr_q <= hcm_addr_d;
      him_addr_q <= him_addr_d;
      done_q     <= done_d;
      no_hits_q  <= no_hits_d;
      ovf_q      <= ovf_d;
      aborted_q  <= aborted_d;
    end
  end

  block_memory_retrieval_hit_row_serializer u_serializer (
    .clk_i       (clock),
    .rst_ni      (resetN),
    .load_i      (load_c),
    .abort_i     (abort_c),
    .row_i       (dataOutputA_HIM),
    .count_i     (n_q),
    .word_o      (hitInfo),
    .valid_o     (hitValid),
    .last_o      (lastHit),
    .remaining_o (ser_remaining)
  );

  assign rowIndexA_HNM = hnm_addr_q;
  assign rowIndexA_HCM = hcm_addr_q;
  assign rowIndexA_HIM = him_addr_q;
  assign readDone      = done_q;
  assign noHits        = no_hits_q;
  assign countOverflow = ovf_q;
  assign readAborted   = aborted_q;

endmodule
